// File: rtl/jpeg2bmp_mul_pkg.sv
// ---------------------------------------------------------------------------
// jpeg2bmp_mul_pkg
// Shared types and helpers for the rounding pipelined multiplier.
//   MUL_MAX_STAGE : deepest legal pipeline
//   MUL_MAX_W     : working width for rounding/narrowing arithmetic; it must
//                   exceed the full product width by at least 2 bits so the
//                   rounding add and the clamp limits never wrap
//   rnd_shift()   : round-half-up right shift (ties toward +inf)
//   sat_narrow()  : clamp to a signed/unsigned result width, flag overflow
// ---------------------------------------------------------------------------
package jpeg2bmp_mul_pkg;

  localparam int unsigned MUL_MAX_STAGE = 8;
  localparam int unsigned MUL_MAX_W     = 128;

  typedef logic signed [MUL_MAX_W-1:0] mul_wide_t;

  typedef struct packed {
    mul_wide_t val;
    logic      ovf;
  } sat_res_t;

  localparam mul_wide_t MUL_ONE = {{(MUL_MAX_W-1){1'b0}}, 1'b1};

  // Adds half an LSB of the result, then shifts arithmetically. Unsigned
  // products arrive zero-extended, so the arithmetic shift is also correct
  // for them.
  function automatic mul_wide_t rnd_shift(input mul_wide_t p, input int unsigned shift);
    mul_wide_t half_v;
    if (shift > 32'd0) begin
      half_v = MUL_ONE <<< (shift - 32'd1);
    end else begin
      half_v = {MUL_MAX_W{1'b0}};
    end
    return (p + half_v) >>> shift;
  endfunction

  // Clamps r into the representable range of a width-bit result.
  function automatic sat_res_t sat_narrow(input mul_wide_t r, input int unsigned width,
                                          input logic is_signed);
    mul_wide_t hi_v;
    mul_wide_t lo_v;
    sat_res_t  res;
    if (is_signed) begin
      hi_v = (MUL_ONE <<< (width - 32'd1)) - MUL_ONE;
      lo_v = -(MUL_ONE <<< (width - 32'd1));
    end else begin
      hi_v = (MUL_ONE <<< width) - MUL_ONE;
      lo_v = {MUL_MAX_W{1'b0}};
    end
    res.val = r;
    res.ovf = 1'b0;
    if (r > hi_v) begin
      res.val = hi_v;
      res.ovf = 1'b1;
    end else if (r < lo_v) begin
      res.val = lo_v;
      res.ovf = 1'b1;
    end else begin
      res.ovf = 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/jpeg2bmp_mul_delay.sv
// ---------------------------------------------------------------------------
// jpeg2bmp_mul_delay
// Generic ce-gated shift register, DEPTH stages of WIDTH bits, clearing
// synchronously to 0 on reset (reset wins over ce).
//   clk, reset : clock, synchronous active-high reset
//   ce         : advance enable; 0 holds every stage
//   d / q      : input / output of the chain (q is d delayed DEPTH ce-cycles)
// ---------------------------------------------------------------------------
module jpeg2bmp_mul_delay
  import jpeg2bmp_mul_pkg::*;
#(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ce,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_r [DEPTH];

  // Shift chain: clear on reset, advance one stage per enabled cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        stage_r[i] <= {WIDTH{1'b0}};
      end
    end else if (ce) begin
      stage_r[0] <= d;
      for (int i = 1; i < int'(DEPTH); i++) begin
        stage_r[i] <= stage_r[i-1];
      end
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        stage_r[i] <= stage_r[i];
      end
    end
  end

  assign q = stage_r[DEPTH-1];

endmodule

// File: rtl/jpeg2bmp_mul_pipe_rnd.sv
// ---------------------------------------------------------------------------
// jpeg2bmp_mul_pipe_rnd
// N-stage pipelined multiplier with valid tracking, signed/unsigned operands,
// round-half-up right shift by SHIFT and narrowing to dout_WIDTH.
// Optional feature macro: JPEG2BMP_MUL_SAT_EN
//   defined   : result clamps to the dout_WIDTH range, ovf flags clamping
//   undefined : result wraps (low dout_WIDTH bits), ovf tied to 0
// Ports:
//   clk, reset      : clock, synchronous active-high reset (overrides ce)
//   ce              : clock enable, 0 freezes the whole pipeline
//   in_vld          : din0/din1 carry a sample
//   din0, din1      : operands
//   out_vld         : dout carries a result (NUM_STAGE ce-cycles after accept)
//   dout            : rounded, narrowed product
//   ovf             : narrowing clamped the current result (qualified by out_vld)
// The product is formed combinationally and carried through NUM_STAGE-1
// delay stages; rounding and narrowing feed the output register, which is
// the last stage. Retiming can spread the multiplier over the delay stages.
// ---------------------------------------------------------------------------
module jpeg2bmp_mul_pipe_rnd
  import jpeg2bmp_mul_pkg::*;
#(
  parameter int          ID         = 1,
  parameter int unsigned NUM_STAGE  = 3,
  parameter int unsigned din0_WIDTH = 32,
  parameter int unsigned din1_WIDTH = 10,
  parameter int unsigned dout_WIDTH = 32,
  parameter int unsigned SIGNED0    = 1,
  parameter int unsigned SIGNED1    = 1,
  parameter int unsigned SHIFT      = 9
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  in_vld,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  out_vld,
  output logic [dout_WIDTH-1:0] dout,
  output logic                  ovf
);

  localparam int unsigned PW       = din0_WIDTH + din1_WIDTH;
  localparam bit          P_SIGNED = (SIGNED0 != 32'd0) || (SIGNED1 != 32'd0);
  // ID is only an instance tag; it takes part in the legality check alone.
  localparam bit CFG_OK = (ID >= 0) && (NUM_STAGE >= 32'd1) && (NUM_STAGE <= MUL_MAX_STAGE) &&
                          (dout_WIDTH >= 32'd1) && (dout_WIDTH <= PW) && (SHIFT < PW) &&
                          (PW + 32'd2 <= MUL_MAX_W);

  mul_wide_t             a_ext_s;
  mul_wide_t             b_ext_s;
  logic [PW-1:0]         prod_s;
  logic [PW-1:0]         prod_d_s;
  logic                  vld_d_s;
  mul_wide_t             p_ext_s;
  mul_wide_t             rnd_s;
  logic [dout_WIDTH-1:0] dout_nxt_s;
  logic                  out_vld_r;
  logic [dout_WIDTH-1:0] dout_r;

  // Operand extension and full-width product. Every signedness mix fits
  // exactly in PW bits, so the wide product is simply truncated.
  always_comb begin
    if (SIGNED0 != 32'd0) begin
      a_ext_s = {{(MUL_MAX_W-din0_WIDTH){din0[din0_WIDTH-1]}}, din0};
    end else begin
      a_ext_s = {{(MUL_MAX_W-din0_WIDTH){1'b0}}, din0};
    end
    if (SIGNED1 != 32'd0) begin
      b_ext_s = {{(MUL_MAX_W-din1_WIDTH){din1[din1_WIDTH-1]}}, din1};
    end else begin
      b_ext_s = {{(MUL_MAX_W-din1_WIDTH){1'b0}}, din1};
    end
    prod_s = PW'(a_ext_s * b_ext_s);
  end

  generate
    if (NUM_STAGE > 32'd1) begin : g_dly
      logic [PW:0] dly_q_s;
      jpeg2bmp_mul_delay #(
        .WIDTH (PW + 32'd1),
        .DEPTH (NUM_STAGE - 32'd1)
      ) u_dly (
        .clk   (clk),
        .reset (reset),
        .ce    (ce),
        .d     ({in_vld, prod_s}),
        .q     (dly_q_s)
      );
      assign vld_d_s  = dly_q_s[PW];
      assign prod_d_s = dly_q_s[PW-1:0];
    end else begin : g_nodly
      assign vld_d_s  = in_vld;
      assign prod_d_s = prod_s;
    end
  endgenerate

  // Re-extend the carried product by its signedness and round it.
  always_comb begin
    if (P_SIGNED) begin
      p_ext_s = {{(MUL_MAX_W-PW){prod_d_s[PW-1]}}, prod_d_s};
    end else begin
      p_ext_s = {{(MUL_MAX_W-PW){1'b0}}, prod_d_s};
    end
    rnd_s = rnd_shift(p_ext_s, SHIFT);
  end

`ifdef JPEG2BMP_MUL_SAT_EN
  sat_res_t sat_s;
  logic     ovf_nxt_s;
  logic     ovf_r;

  // Clamp to the result range; overflow is only meaningful for real samples.
  always_comb begin
    sat_s      = sat_narrow(rnd_s, dout_WIDTH, P_SIGNED);
    dout_nxt_s = dout_WIDTH'(sat_s.val);
    ovf_nxt_s  = vld_d_s & sat_s.ovf;
  end

  // Overflow flag register, aligned with dout.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_r <= 1'b0;
    end else if (ce) begin
      ovf_r <= ovf_nxt_s;
    end else begin
      ovf_r <= ovf_r;
    end
  end
`else
  // Wrapping narrow: keep the low result bits.
  always_comb begin
    dout_nxt_s = dout_WIDTH'(rnd_s);
  end
`endif

  // Final pipeline stage: registered valid and result.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_vld_r <= 1'b0;
      dout_r    <= {dout_WIDTH{1'b0}};
    end else if (ce) begin
      out_vld_r <= vld_d_s;
      dout_r    <= dout_nxt_s;
    end else begin
      out_vld_r <= out_vld_r;
      dout_r    <= dout_r;
    end
  end

  // An illegal parameterisation elaborates to an inert block.
  generate
    if (CFG_OK) begin : g_out
      assign out_vld = out_vld_r;
      assign dout    = dout_r;
`ifdef JPEG2BMP_MUL_SAT_EN
      assign ovf     = ovf_r;
`else
      assign ovf     = 1'b0;
`endif
    end else begin : g_out_off
      assign out_vld = 1'b0;
      assign dout    = {dout_WIDTH{1'b0}};
      assign ovf     = 1'b0;
    end
  endgenerate

endmodule
